// File: rtl/sha256_pkg.sv
// Shared encodings and widths for the SHA-256 block sequencer and its round counter.
package sha256_pkg;
    localparam int ROUNDS_DEFAULT = 64;
    localparam int BSEL_W         = 2;
    localparam int IDX_W          = 6;
    localparam logic [BSEL_W-1:0] BLK_IV = 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        INIT,
        RUN,
        FOLD,
        RESEED,
        DONE
    } state_t;
endpackage

// File: rtl/sha256_block_sequencer_if.sv
// Control bundle between the sequencer, the mining top level, the loader and the datapath.
// The dbl input exists only when SHA_DOUBLE_HASH_EN is defined.
interface sha256_block_sequencer_if;
    import sha256_pkg::*;

    logic              start;
    logic [1:0]        nblocks;
`ifdef SHA_DOUBLE_HASH_EN
    logic              dbl;
`endif
    logic              blk_req;
    logic              blk_ack;
    logic              round_en;
    logic [IDX_W-1:0]  round_idx;
    logic              init_vars;
    logic [BSEL_W-1:0] block_sel;
    logic              busy;
    logic              done;

`ifdef SHA_DOUBLE_HASH_EN
    modport master (input start, nblocks, dbl, blk_ack,
                    output blk_req, round_en, round_idx, init_vars, block_sel, busy, done);
    modport slave  (output start, nblocks, dbl, blk_ack,
                    input blk_req, round_en, round_idx, init_vars, block_sel, busy, done);
`else
    modport master (input start, nblocks, blk_ack,
                    output blk_req, round_en, round_idx, init_vars, block_sel, busy, done);
    modport slave  (output start, nblocks, blk_ack,
                    input blk_req, round_en, round_idx, init_vars, block_sel, busy, done);
`endif
endinterface

// File: rtl/sha256_round_counter.sv
// Round index counter: counts 0..ROUNDS-1 while enabled, wraps, flags the last round.
module sha256_round_counter
    import sha256_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    assign tc = (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr)
            idx <= '0;
        else if (en)
            idx <= tc ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/sha256_block_sequencer.sv
// Sequences request / init / rounds / fold for each block of one SHA-256 hash.
// Define SHA_DOUBLE_HASH_EN to add a second single-block pass over the first digest.
module sha256_block_sequencer
    import sha256_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEFAULT,
    parameter int MAX_BLOCKS = 3
) (
    input logic                      clk,
    input logic                      rst,
    sha256_block_sequencer_if.master bus
);
    localparam logic [BSEL_W-1:0] MAXB = BSEL_W'(MAX_BLOCKS);
    localparam logic [BSEL_W-1:0] ONE  = BSEL_W'(1);

    state_t            state;
    logic [BSEL_W-1:0] blk_cnt;
    logic [BSEL_W-1:0] nb_lat;
    logic              tc;
`ifdef SHA_DOUBLE_HASH_EN
    logic              dbl_pend;
`endif

    // round_en is registered, so the counter runs exactly while RUN is active
    sha256_round_counter #(.ROUNDS(ROUNDS)) u_rc (
        .clk (clk),
        .rst (rst),
        .en  (bus.round_en),
        .clr (state == INIT),
        .idx (bus.round_idx),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.blk_req   <= 1'b0;
            bus.round_en  <= 1'b0;
            bus.init_vars <= 1'b0;
            bus.block_sel <= BLK_IV;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            blk_cnt       <= '0;
            nb_lat        <= '0;
`ifdef SHA_DOUBLE_HASH_EN
            dbl_pend      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    bus.block_sel <= BLK_IV;
                    if (bus.start) begin
                        nb_lat      <= (bus.nblocks == '0)  ? ONE  :
                                       (bus.nblocks > MAXB) ? MAXB : bus.nblocks;
                        blk_cnt     <= ONE;
                        bus.busy    <= 1'b1;
                        bus.blk_req <= 1'b1;
`ifdef SHA_DOUBLE_HASH_EN
                        dbl_pend    <= bus.dbl;
`endif
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (bus.blk_ack) begin
                        bus.blk_req   <= 1'b0;
                        bus.init_vars <= 1'b1;
                        state         <= INIT;
                    end
                end
                INIT: begin
                    bus.init_vars <= 1'b0;
                    bus.round_en  <= 1'b1;
                    state         <= RUN;
                end
                RUN: begin
                    if (tc) begin
                        bus.round_en  <= 1'b0;
                        bus.block_sel <= blk_cnt;
                        state         <= FOLD;
                    end
                end
                FOLD: begin
                    // block_sel keeps the folded block number until IDLE/RESEED
                    if (blk_cnt == nb_lat) begin
`ifdef SHA_DOUBLE_HASH_EN
                        if (dbl_pend) begin
                            dbl_pend      <= 1'b0;
                            bus.block_sel <= BLK_IV;
                            state         <= RESEED;
                        end else
`endif
                        begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        blk_cnt     <= blk_cnt + 1'b1;
                        bus.blk_req <= 1'b1;
                        state       <= REQ;
                    end
                end
`ifdef SHA_DOUBLE_HASH_EN
                RESEED: begin
                    blk_cnt     <= ONE;
                    nb_lat      <= ONE;
                    bus.blk_req <= 1'b1;
                    state       <= REQ;
                end
`endif
                DONE: begin
                    bus.done      <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.block_sel <= BLK_IV;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer: counts rounds, handshakes and block_sel changes per hash.
module tb_sha256_block_sequencer;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_block_sequencer_if bus ();

    sha256_block_sequencer #(.ROUNDS(64), .MAX_BLOCKS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int          done_cyc, done_cnt, n_round, idx_err, n_hs, init_cnt, req_min, req_max, busy_err;
    logic [31:0] bsel_log;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs_packed();
        return 32'({bus.blk_req, bus.round_en, bus.round_idx, bus.init_vars,
                    bus.block_sel, bus.busy, bus.done});
    endfunction

    // d=0: blk_ack tied high; d>0: ack on the d-th cycle of each request.
    // inject: cycle at which a stray start/ack/nblocks change is applied.
    // abort: assert rst at round_idx 30 of block 2 and return.
    task automatic run(input logic [1:0] nb, input logic dv, input int d,
                       input int inject, input bit abort);
        int          exp_idx;
        int          req_run;
        logic [1:0]  prev_bsel;
        done_cyc = 0; done_cnt = 0; n_round = 0; idx_err = 0; n_hs = 0;
        init_cnt = 0; req_min = 999; req_max = 0; busy_err = 0; bsel_log = '0;
        exp_idx = 0; req_run = 0; prev_bsel = 2'd0;
        bus.start   = 1'b1;
        bus.nblocks = nb;
`ifdef SHA_DOUBLE_HASH_EN
        bus.dbl     = dv;
`else
        if (dv) $display("note: dbl ignored in this build");
`endif
        bus.blk_ack = (d == 0);
        tick;
        bus.start   = 1'b0;
        bus.nblocks = ~nb;
        for (int c = 1; c <= 400; c++) begin
            if (bus.round_en) begin
                n_round++;
                if (32'(bus.round_idx) !== exp_idx) idx_err++;
                exp_idx = (exp_idx + 1) % 64;
            end
            if (bus.init_vars) init_cnt++;
            if (bus.block_sel !== prev_bsel) begin
                bsel_log  = {bsel_log[27:0], 2'b00, bus.block_sel};
                prev_bsel = bus.block_sel;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (!bus.busy && done_cnt == 0) busy_err++;
            if (bus.blk_req) req_run++;
            else if (req_run > 0) begin
                n_hs++;
                if (req_run < req_min) req_min = req_run;
                if (req_run > req_max) req_max = req_run;
                req_run = 0;
            end
            if (abort && bus.block_sel == 2'd1 && bus.round_en && bus.round_idx == 6'd30) begin
                rst = 1'b1;
                tick;
                rst = 1'b0;
                bus.blk_ack = 1'b0;
                return;
            end
            if (d != 0) bus.blk_ack = bus.blk_req && (req_run >= d);
            if (c == inject) begin
                bus.start   = 1'b1;
                bus.blk_ack = 1'b1;
                bus.nblocks = 2'd3;
            end else if (c == inject + 1) begin
                bus.start = 1'b0;
            end
            if (done_cnt > 0 && c >= done_cyc + 2) break;
            tick;
        end
        bus.blk_ack = 1'b0;
        bus.start   = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.nblocks = 2'd0;
        bus.blk_ack = 1'b0;
`ifdef SHA_DOUBLE_HASH_EN
        bus.dbl     = 1'b0;
`endif
        rst = 1'b1;
        tick; tick;
        check("reset_outputs", outs_packed(), 32'd0);
        rst = 1'b0;
        tick;
        check("idle_outputs", outs_packed(), 32'd0);

        // single block, ack tied high
        run(2'd1, 1'b0, 0, 0, 1'b0);
        check("nb1_done_cycle", done_cyc, 32'd68);
        check("nb1_done_count", done_cnt, 32'd1);
        check("nb1_rounds", n_round, 32'd64);
        check("nb1_idx_seq", idx_err, 32'd0);
        check("nb1_bsel_seq", bsel_log, 32'h10);
        check("nb1_handshakes", n_hs, 32'd1);
        check("nb1_init_pulses", init_cnt, 32'd1);
        check("nb1_busy", busy_err, 32'd0);
        check("nb1_after_idle", outs_packed(), 32'd0);

        // two blocks, each ack after 5 request cycles
        run(2'd2, 1'b0, 5, 0, 1'b0);
        check("nb2_done_cycle", done_cyc, 32'd143);
        check("nb2_done_count", done_cnt, 32'd1);
        check("nb2_rounds", n_round, 32'd128);
        check("nb2_idx_seq", idx_err, 32'd0);
        check("nb2_bsel_seq", bsel_log, 32'h120);
        check("nb2_handshakes", n_hs, 32'd2);
        check("nb2_req_min", req_min, 32'd5);
        check("nb2_req_max", req_max, 32'd5);
        check("nb2_init_pulses", init_cnt, 32'd2);

        // nblocks=0 treated as 1
        run(2'd0, 1'b0, 0, 0, 1'b0);
        check("nb0_done_cycle", done_cyc, 32'd68);
        check("nb0_rounds", n_round, 32'd64);
        check("nb0_bsel_seq", bsel_log, 32'h10);

        // stray start/ack/nblocks during RUN must be ignored
        run(2'd1, 1'b0, 2, 20, 1'b0);
        check("ign_done_cycle", done_cyc, 32'd69);
        check("ign_done_count", done_cnt, 32'd1);
        check("ign_rounds", n_round, 32'd64);
        check("ign_idx_seq", idx_err, 32'd0);
        check("ign_bsel_seq", bsel_log, 32'h10);

        // reset mid-RUN of block 2, then a clean hash
        run(2'd2, 1'b0, 0, 0, 1'b1);
        check("abort_rounds_seen", n_round, 32'd95);
        check("abort_reset_outputs", outs_packed(), 32'd0);
        tick;
        check("abort_stays_idle", outs_packed(), 32'd0);
        run(2'd2, 1'b0, 0, 0, 1'b0);
        check("rerun_done_cycle", done_cyc, 32'd135);
        check("rerun_bsel_seq", bsel_log, 32'h120);
        check("rerun_rounds", n_round, 32'd128);

`ifdef SHA_DOUBLE_HASH_EN
        run(2'd2, 1'b1, 0, 0, 1'b0);
        check("dbl_done_cycle", done_cyc, 32'd203);
        check("dbl_done_count", done_cnt, 32'd1);
        check("dbl_rounds", n_round, 32'd192);
        check("dbl_bsel_seq", bsel_log, 32'h12010);
        check("dbl_handshakes", n_hs, 32'd3);
        check("dbl_busy", busy_err, 32'd0);
        run(2'd2, 1'b0, 0, 0, 1'b0);
        check("dbl0_done_cycle", done_cyc, 32'd135);
        check("dbl0_bsel_seq", bsel_log, 32'h120);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
